// File: rtl/secure_enc_pkg.sv
// Shared constants, word type and rotate helpers for the secure_encryption_module pipeline.
package secure_enc_pkg;

  localparam int unsigned N_DEFAULT      = 8;
  localparam int unsigned ROUNDS_DEFAULT = 2;

  typedef logic [N_DEFAULT-1:0] word_t;

  // Destination bit position of source bit i after an n-bit rotate-left by k.
  function automatic int unsigned rotl_pos(input int unsigned i, input int unsigned k,
                                           input int unsigned n);
    return (i + (k % n)) % n;
  endfunction

  function automatic word_t rotl(input word_t x, input int unsigned k);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < N_DEFAULT; i++) begin
      r[rotl_pos(i, k, N_DEFAULT)] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/secure_enc_round.sv
// One registered cipher round: s' = rotl(s ^ rotl(K, IDX), 1), with the key copy and valid bit.
// SECURE_ENC_ZEROIZE_EN: a stage whose incoming valid is 0 loads zeros instead of holding.
module secure_enc_round
  import secure_enc_pkg::*;
#(
  parameter int unsigned N   = N_DEFAULT,
  parameter int unsigned IDX = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [N-1:0] state_i,
  input  logic [N-1:0] key_i,
  output logic         valid_o,
  output logic [N-1:0] state_o,
  output logic [N-1:0] key_o
);

  logic         valid_q;
  logic [N-1:0] state_q, state_d;
  logic [N-1:0] key_q;
  logic [N-1:0] rk, mix;

  // Fixed wiring only: IDX and N are elaboration constants, so no data-dependent paths.
  always_comb begin
    rk      = '0;
    mix     = '0;
    state_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rk[rotl_pos(i, IDX, N)] = key_i[i];
    end
    mix = state_i ^ rk;
    for (int unsigned i = 0; i < N; i++) begin
      state_d[rotl_pos(i, 1, N)] = mix[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      valid_q <= valid_i;
`ifdef SECURE_ENC_ZEROIZE_EN
      state_q <= valid_i ? state_d : '0;
      key_q   <= valid_i ? key_i   : '0;
`else
      if (valid_i) begin
        state_q <= state_d;
        key_q   <= key_i;
      end
`endif
    end
  end

  assign valid_o = valid_q;
  assign state_o = state_q;
  assign key_o   = key_q;

endmodule

// File: rtl/secure_encryption_module.sv
// Constant-latency keyed cipher: ROUNDS registered rounds, output whitening with the carried key.
// SECURE_ENC_ZEROIZE_EN clears bubble stages, which also forces data_out to 0 when out_valid is 0.
module secure_encryption_module
  import secure_enc_pkg::*;
#(
  parameter int unsigned N      = N_DEFAULT,
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  output logic [N-1:0] data_out
);

  logic         valid_c [0:ROUNDS];
  logic [N-1:0] state_c [0:ROUNDS];
  logic [N-1:0] key_c   [0:ROUNDS];

  assign valid_c[0] = in_valid;
  assign state_c[0] = data_in;
  assign key_c[0]   = key;

  for (genvar g = 0; g < ROUNDS; g++) begin : g_round
    secure_enc_round #(
      .N   (N),
      .IDX (g)
    ) u_round (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_c[g]),
      .state_i (state_c[g]),
      .key_i   (key_c[g]),
      .valid_o (valid_c[g+1]),
      .state_o (state_c[g+1]),
      .key_o   (key_c[g+1])
    );
  end

  // The last round's registers serve as the output register; whitening is a pure XOR of them,
  // so data_out holds the last ciphertext whenever that stage holds.
  assign out_valid = valid_c[ROUNDS];
  assign data_out  = state_c[ROUNDS] ^ key_c[ROUNDS];

endmodule

// File: tb/tb_secure_encryption_module.sv
// Directed-vector bench for secure_encryption_module (N=8, ROUNDS=2).
module tb_secure_encryption_module;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic [7:0] key;
  logic       out_valid;
  logic [7:0] data_out;

  int n_cmp;
  int n_err;

  // Expectation for the word launched on the previous step, and the last ciphertext seen.
  logic       pv;
  logic [7:0] pd;
  logic [7:0] last_d;

  secure_encryption_module #(
    .N      (8),
    .ROUNDS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .key       (key),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bubble_val(input logic [7:0] held);
`ifdef SECURE_ENC_ZEROIZE_EN
    return 8'h00;
`else
    return held;
`endif
  endfunction

  // Drive one input cycle; e is the hand-computed ciphertext for this word.
  // After the next edge, the word launched on the previous step must be at the output.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic [7:0] k, input logic [7:0] e);
    in_valid = v;
    data_in  = d;
    key      = k;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".vld"}, {7'd0, out_valid}, {7'd0, pv});
    if (pv) begin
      last_d = pd;
      check_eq({tag, ".dat"}, data_out, pd);
    end else begin
      check_eq({tag, ".bub"}, data_out, bubble_val(last_d));
    end
    pv = v;
    pd = e;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    pv       = 1'b0;
    pd       = 8'h00;
    last_d   = 8'h00;
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'hAA;
    key      = 8'hCC;

    // Inputs toggling under reset must not be captured.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst.vld", {7'd0, out_valid}, 8'h00);
      check_eq("rst.dat", data_out, 8'h00);
    end
    rst      = 1'b0;
    in_valid = 1'b0;

    step("idle0", 1'b0, 8'h00, 8'h00, 8'h00);
    step("idle1", 1'b0, 8'h00, 8'h00, 8'h00);

    // Back-to-back words, both encrypt to 66.
    step("aa_cc", 1'b1, 8'hAA, 8'hCC, 8'h66);
    step("55_33", 1'b1, 8'h55, 8'h33, 8'h66);
    step("b2b_a", 1'b0, 8'h00, 8'h00, 8'h00);
    step("b2b_b", 1'b0, 8'h00, 8'h00, 8'h00);
    step("b2b_c", 1'b0, 8'h00, 8'h00, 8'h00);

    // Key changes right behind an in-flight word.
    step("keyA",  1'b1, 8'hAA, 8'hCC, 8'h66);
    step("keyFF", 1'b0, 8'hAA, 8'hFF, 8'h00);
    step("keyB",  1'b1, 8'hAA, 8'hCC, 8'h66);
    step("keyC",  1'b1, 8'hAA, 8'hFF, 8'h55);
    step("keyD",  1'b0, 8'h00, 8'hFF, 8'h00);
    step("keyE",  1'b0, 8'h00, 8'h00, 8'h00);

    // Rotate wrap-around with a bubble between valid words.
    step("r01",   1'b1, 8'h01, 8'h00, 8'h04);
    step("rbub",  1'b0, 8'hFF, 8'hFF, 8'h00);
    step("r80",   1'b1, 8'h80, 8'h00, 8'h02);
    step("r0f",   1'b1, 8'h0F, 8'hF0, 8'hCC);
    step("rfl0",  1'b0, 8'h00, 8'h00, 8'h00);
    step("rfl1",  1'b0, 8'h00, 8'h00, 8'h00);
    step("rfl2",  1'b0, 8'h00, 8'h00, 8'h00);

    // Two words in flight, then an asynchronous reset between edges.
    step("mid0",  1'b1, 8'h12, 8'h34, 8'h00);
    in_valid = 1'b1;
    data_in  = 8'h56;
    key      = 8'h78;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid.vld", {7'd0, out_valid}, 8'h00);
    check_eq("mid.dat", data_out, 8'h00);
    @(negedge clk);
    rst      = 1'b0;
    pv       = 1'b0;
    last_d   = 8'h00;
    step("post0", 1'b0, 8'h00, 8'h00, 8'h00);
    step("post1", 1'b0, 8'h00, 8'h00, 8'h00);
    step("post2", 1'b0, 8'h00, 8'h00, 8'h00);

    step("rec0",  1'b1, 8'hAA, 8'hCC, 8'h66);
    step("rec1",  1'b0, 8'h00, 8'h00, 8'h00);
    step("rec2",  1'b0, 8'h00, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
